// File: rtl/wlb_pkg.sv
// Shared helpers for the sliding-window line buffer: window bit placement
// and the unit used to derive the largest legal row length.
package wlb_pkg;

  // The largest legal row length is WLB_LEN_UNIT << ADDR_BIT.
  localparam logic [31:0] WLB_LEN_UNIT = 32'd1;

  function automatic int win_offset(input int r, input int c, input int k, input int width);
    return (r * k + c) * width;
  endfunction

endpackage

// File: rtl/window_line_buffer_row_delay.sv
// One image row of delay: a circular RAM that is read and then overwritten
// at a single pointer, so dout is the pixel accepted row_len shifts ago.
module row_delay
  import wlb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [ADDR_BIT:0]   row_len,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout
);

  logic [WIDTH-1:0]    mem_q [2**ADDR_BIT];
  logic [ADDR_BIT-1:0] ptr_q, ptr_d;
  logic                ptr_last;

  assign ptr_last = ({1'b0, ptr_q} == row_len - (ADDR_BIT+1)'(1));
  assign dout     = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = ptr_last ? '0 : ptr_q + ADDR_BIT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage contents survive reset and flush; stale data never reaches a valid window.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/window_line_buffer.sv
// K x K sliding window over a raster pixel stream using K-1 row delays.
// Optional feature: define WLB_STRIDE2_EN to add the stride2 input.
module window_line_buffer
  import wlb_pkg::*;
#(
  parameter int K        = 3,
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [ADDR_BIT:0]      row_len,
`ifdef WLB_STRIDE2_EN
  input  logic                   stride2,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [K*K*WIDTH-1:0]   window,
  output logic                   cfg_err
);

  localparam int RW = $clog2(K);
  localparam logic [ADDR_BIT:0] LEN_MAX = (ADDR_BIT+1)'(WLB_LEN_UNIT << ADDR_BIT);
  localparam logic [ADDR_BIT:0] LEN_MIN = (ADDR_BIT+1)'(K);
  localparam logic [RW-1:0]     ROW_TOP = RW'(K-1);
  localparam logic [ADDR_BIT-1:0] COL_FIRST = ADDR_BIT'(K-1);

  logic [ADDR_BIT-1:0] col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [ADDR_BIT:0]   len_q, len_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    win_q [K][K];
  logic [WIDTH-1:0]    win_d [K][K];
  logic [WIDTH-1:0]    dly_in  [K-1];
  logic [WIDTH-1:0]    dly_out [K-1];
  logic                accept, col_last, emit;

  assign cfg_err   = (len_q < LEN_MIN) || (len_q > LEN_MAX);
  assign in_ready  = rst && !clr && !cfg_err && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign col_last  = ({1'b0, col_q} == len_q - (ADDR_BIT+1)'(1));
  assign out_valid = out_valid_q;

`ifdef WLB_STRIDE2_EN
  localparam logic KM1_LSB = 1'((K-1) % 2);
  logic stride2_q, rowpar_q;

  // Parity keeps counting after row saturates so every other image row qualifies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride2_q <= 1'b0;
      rowpar_q  <= 1'b0;
    end else if (clr) begin
      stride2_q <= stride2;
      rowpar_q  <= 1'b0;
    end else if (accept && col_last) begin
      rowpar_q  <= ~rowpar_q;
    end
  end

  assign emit = (row_q == ROW_TOP) && (col_q >= COL_FIRST) &&
                (!stride2_q || ((col_q[0] == KM1_LSB) && !rowpar_q));
`else
  assign emit = (row_q == ROW_TOP) && (col_q >= COL_FIRST);
`endif

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    win_d       = win_q;
    if (clr) begin
      col_d       = '0;
      row_d       = '0;
      len_d       = row_len;
      out_valid_d = 1'b0;
      win_d       = '{default: '0};
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        col_d = col_last ? '0 : col_q + ADDR_BIT'(1);
        if (col_last && (row_q != ROW_TOP)) begin
          row_d = row_q + RW'(1);
        end
        if (emit) begin
          out_valid_d = 1'b1;
        end
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) begin
            win_d[r][c] = win_q[r][c+1];
          end
          win_d[r][K-1] = (r == K - 1) ? in : dly_out[r];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      len_q       <= LEN_MAX;
      out_valid_q <= 1'b0;
      win_q       <= '{default: '0};
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
    end
  end

  // Delay K-2 sees the newest pixel; each lower delay is fed by the one above.
  genvar gi, gj;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_dly
      if (gi == K - 2) begin : g_top
        assign dly_in[gi] = in;
      end else begin : g_chain
        assign dly_in[gi] = dly_out[gi+1];
      end

      row_delay #(
        .WIDTH    (WIDTH),
        .ADDR_BIT (ADDR_BIT)
      ) u_row_delay (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .en      (accept),
        .row_len (len_q),
        .din     (dly_in[gi]),
        .dout    (dly_out[gi])
      );
    end

    for (gi = 0; gi < K; gi++) begin : g_row
      for (gj = 0; gj < K; gj++) begin : g_col
        assign window[win_offset(gi, gj, K, WIDTH) +: WIDTH] = win_q[gi][gj];
      end
    end
  endgenerate

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer (K=3, WIDTH=8, ADDR_BIT=3).
module tb_window_line_buffer;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [3:0]  row_len;
  logic [7:0]  din;
  logic        in_ready, out_valid, cfg_err;
  logic [71:0] window;
`ifdef WLB_STRIDE2_EN
  logic        stride2 = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [71:0] w_exp;

  always #5 clk = ~clk;

  window_line_buffer #(.K(3), .WIDTH(8), .ADDR_BIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .row_len   (row_len),
`ifdef WLB_STRIDE2_EN
    .stride2   (stride2),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .window    (window),
    .cfg_err   (cfg_err)
  );

  function automatic logic [71:0] mkwin(input int a0, input int a1, input int a2,
                                        input int b0, input int b1, input int b2,
                                        input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0), 8'(b2), 8'(b1), 8'(b0), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    din      = 8'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr(input logic [3:0] len);
    row_len = len;
    clr     = 1'b1;
    @(posedge clk); #1;
    clr     = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b1; row_len = 4'd4;
    #12;
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_window", window, 72'(0));
    chk("rst_cfg_err", 72'(cfg_err), 72'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // clr wins over a simultaneous pixel
    row_len = 4'd4; clr = 1'b1; in_valid = 1'b1; din = 8'd99; #1;
    chk("clr_in_ready", 72'(in_ready), 72'(0));
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_cfg_err", 72'(cfg_err), 72'(0));
    chk("clr_out_valid", 72'(out_valid), 72'(0));

    for (int n = 0; n < 10; n++) begin
      push(n);
      chk($sformatf("no_win_%0d", n), 72'(out_valid), 72'(0));
    end
    push(10);
    chk("win10_valid", 72'(out_valid), 72'(1));
    chk("win10", window, mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10));
    push(11);
    chk("win11_valid", 72'(out_valid), 72'(1));
    chk("win11", window, mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11));
    push(12);
    chk("no_win_12", 72'(out_valid), 72'(0));
    push(13);
    chk("no_win_13", 72'(out_valid), 72'(0));
    push(14);
    chk("win14_valid", 72'(out_valid), 72'(1));
    w_exp = mkwin(4, 5, 6, 8, 9, 10, 12, 13, 14);
    chk("win14", window, w_exp);

    // Backpressure: window frozen, pixel 15 held until release
    out_ready = 1'b0; in_valid = 1'b1; din = 8'd15; #1;
    chk("stall_in_ready", 72'(in_ready), 72'(0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_valid_%0d", i), 72'(out_valid), 72'(1));
      chk($sformatf("stall_win_%0d", i), window, w_exp);
    end
    out_ready = 1'b1; #1;
    chk("release_in_ready", 72'(in_ready), 72'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("win15_valid", 72'(out_valid), 72'(1));
    chk("win15", window, mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15));
    push(16);
    chk("no_win_16", 72'(out_valid), 72'(0));

    // Flush mid-frame and restart
    pulse_clr(4'd4);
    for (int n = 0; n < 7; n++) push(n);
    row_len = 4'd4; clr = 1'b1; #1;
    chk("midclr_in_ready", 72'(in_ready), 72'(0));
    @(posedge clk); #1;
    clr = 1'b0;
    chk("midclr_out_valid", 72'(out_valid), 72'(0));
    chk("midclr_window", window, 72'(0));
    for (int n = 0; n < 10; n++) push(n);
    chk("restart_no_win_9", 72'(out_valid), 72'(0));
    push(10);
    chk("restart_win10_valid", 72'(out_valid), 72'(1));
    chk("restart_win10", window, mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10));

    // Asynchronous reset while a window is pending
    out_ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 72'(out_valid), 72'(0));
    chk("async_rst_window", window, 72'(0));
    chk("async_rst_in_ready", 72'(in_ready), 72'(0));
    @(posedge clk); #1;
    chk("async_rst_cfg_err", 72'(cfg_err), 72'(0));
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Illegal row lengths
    pulse_clr(4'd2);
    chk("len2_cfg_err", 72'(cfg_err), 72'(1));
    in_valid = 1'b1; #1;
    chk("len2_in_ready", 72'(in_ready), 72'(0));
    for (int n = 0; n < 12; n++) begin
      din = 8'(n);
      @(posedge clk); #1;
      chk($sformatf("len2_no_win_%0d", n), 72'(out_valid), 72'(0));
    end
    in_valid = 1'b0;
    pulse_clr(4'd9);
    chk("len9_cfg_err", 72'(cfg_err), 72'(1));
    pulse_clr(4'd8);
    chk("len8_cfg_err", 72'(cfg_err), 72'(0));

    // Shortest legal row: row_len == K
    pulse_clr(4'd3);
    chk("len3_cfg_err", 72'(cfg_err), 72'(0));
    for (int n = 0; n < 8; n++) push(n);
    chk("len3_no_win_7", 72'(out_valid), 72'(0));
    push(8);
    chk("len3_win8_valid", 72'(out_valid), 72'(1));
    chk("len3_win8", window, mkwin(0, 1, 2, 3, 4, 5, 6, 7, 8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
